// File: rtl/dot_accum.sv
// Dot-product accumulator behind the registered 8x8 multiplier: sums LEN
// consecutive unsigned products with saturation and presents each result on a
// registered valid/ready port, stalling the product stream until it is taken.
module dot_accum #(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 8
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [IN_W-1:0]              in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [ACC_W-1:0]             out_data,
  output logic                         out_ovf,
  input  logic                         out_ready,
  output logic [1:0]                   dbg_state,
  output logic [((LEN > 1) ? $clog2(LEN) : 1)-1:0] dbg_cnt
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_flag;

  logic [ACC_W-1:0]   base;
  logic [ACC_W:0]     sum;
  logic               sat;
  logic [ACC_W-1:0]   clamped;
  logic               last;

  // Handshake: a product transfers on any edge where in_valid & in_ready;
  // a result transfers on any edge where out_valid & out_ready. in_ready
  // depends on state only, so a pending result always costs one bubble.
  assign in_ready  = (state != HOLD);
  assign dbg_state = state;
  assign dbg_cnt   = cnt;

  always_comb begin
    base    = (state == ACCUM) ? acc : '0;
    sum     = {1'b0, base} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
    sat     = sum[ACC_W];
    clamped = sat ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    last    = (cnt == CNT_W'(LEN - 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      // out_data deliberately keeps its last value across an abort
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ovf_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (in_valid) begin
            if (last) begin
              out_data  <= clamped;
              out_ovf   <= ovf_flag | sat;
              out_valid <= 1'b1;
              state     <= HOLD;
              cnt       <= '0;
              acc       <= '0;
              ovf_flag  <= 1'b0;
            end else begin
              acc       <= clamped;
              cnt       <= cnt + CNT_W'(1);
              ovf_flag  <= ovf_flag | sat;
              state     <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
// Directed bench for dot_accum: four instances with different ACC_W/LEN share
// one stimulus bus; each scenario resets and observes only its own instance.
module tb_dot_accum;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  // LEN=8, ACC_W=24
  logic        in_ready8, out_valid8, out_ovf8;
  logic [23:0] out_data8;
  logic [1:0]  st8;
  logic [2:0]  cnt8;
  // LEN=4, ACC_W=24
  logic        in_ready4, out_valid4, out_ovf4;
  logic [23:0] out_data4;
  logic [1:0]  st4;
  logic [1:0]  cnt4;
  // LEN=8, ACC_W=18
  logic        in_ready18, out_valid18, out_ovf18;
  logic [17:0] out_data18;
  logic [1:0]  st18;
  logic [2:0]  cnt18;
  // LEN=1, ACC_W=24
  logic        in_ready1, out_valid1, out_ovf1;
  logic [23:0] out_data1;
  logic [1:0]  st1;
  logic [0:0]  cnt1;

  always #5 clk = ~clk;

  dot_accum #(.IN_W(16), .ACC_W(24), .LEN(8)) u8 (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready8), .out_valid(out_valid8), .out_data(out_data8),
    .out_ovf(out_ovf8), .out_ready(out_ready), .dbg_state(st8), .dbg_cnt(cnt8));

  dot_accum #(.IN_W(16), .ACC_W(24), .LEN(4)) u4 (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
    .out_ovf(out_ovf4), .out_ready(out_ready), .dbg_state(st4), .dbg_cnt(cnt4));

  dot_accum #(.IN_W(16), .ACC_W(18), .LEN(8)) u18 (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready18), .out_valid(out_valid18), .out_data(out_data18),
    .out_ovf(out_ovf18), .out_ready(out_ready), .dbg_state(st18), .dbg_cnt(cnt18));

  dot_accum #(.IN_W(16), .ACC_W(24), .LEN(1)) u1 (
    .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
    .out_ovf(out_ovf1), .out_ready(out_ready), .dbg_state(st1), .dbg_cnt(cnt1));

  // Every task runs with time sitting 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid8); end
    total++; if (out_data8 !== 24'd0) begin bad++; $display("FAIL reset_out_data got=%0d exp=0", out_data8); end
    total++; if (out_ovf8 !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%0b exp=0", out_ovf8); end
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready8); end
    total++; if (cnt8 !== 3'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt8); end
    total++; if (st8 !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", st8); end
  endtask

  task automatic test_len8();
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      step();
      if (i < 8) begin
        total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL len8_early_valid i=%0d got=%0b exp=0", i, out_valid8); end
      end
    end
    in_valid = 1'b0;
    total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL len8_valid got=%0b exp=1", out_valid8); end
    total++; if (out_data8 !== 24'd36) begin bad++; $display("FAIL len8_data got=%0d exp=36", out_data8); end
    total++; if (out_ovf8 !== 1'b0) begin bad++; $display("FAIL len8_ovf got=%0b exp=0", out_ovf8); end
    total++; if (in_ready8 !== 1'b0) begin bad++; $display("FAIL len8_bubble got=%0b exp=0", in_ready8); end
    step();
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL len8_drain_valid got=%0b exp=0", out_valid8); end
    total++; if (in_ready8 !== 1'b1) begin bad++; $display("FAIL len8_ready_back got=%0b exp=1", in_ready8); end
    out_ready = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'd65025;
      step();
    end
    total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0b exp=1", out_valid4); end
    total++; if (out_data4 !== 24'd260100) begin bad++; $display("FAIL hold_data got=%0d exp=260100", out_data4); end
    in_data = 16'd7;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL hold_stall_valid c=%0d got=%0b exp=1", c, out_valid4); end
      total++; if (out_data4 !== 24'd260100) begin bad++; $display("FAIL hold_stable c=%0d got=%0d exp=260100", c, out_data4); end
      total++; if (in_ready4 !== 1'b0) begin bad++; $display("FAIL hold_in_ready c=%0d got=%0b exp=0", c, in_ready4); end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL hold_release_valid got=%0b exp=0", out_valid4); end
    total++; if (cnt4 !== 2'd0) begin bad++; $display("FAIL hold_no_accept got=%0d exp=0", cnt4); end
    step();
    total++; if (cnt4 !== 2'd1) begin bad++; $display("FAIL hold_next_accept_cnt got=%0d exp=1", cnt4); end
    total++; if (st4 !== 2'd1) begin bad++; $display("FAIL hold_next_state got=%0d exp=1", st4); end
    in_data = 16'd1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL hold_window2_valid got=%0b exp=1", out_valid4); end
    total++; if (out_data4 !== 24'd10) begin bad++; $display("FAIL hold_window2_data got=%0d exp=10", out_data4); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'd65025;
      step();
    end
    in_valid = 1'b0;
    total++; if (out_valid18 !== 1'b1) begin bad++; $display("FAIL sat_valid got=%0b exp=1", out_valid18); end
    total++; if (out_data18 !== 18'd262143) begin bad++; $display("FAIL sat_data got=%0d exp=262143", out_data18); end
    total++; if (out_ovf18 !== 1'b1) begin bad++; $display("FAIL sat_ovf got=%0b exp=1", out_ovf18); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 16'd1;
      step();
    end
    in_valid = 1'b0;
    total++; if (out_data18 !== 18'd8) begin bad++; $display("FAIL sat_next_data got=%0d exp=8", out_data18); end
    total++; if (out_ovf18 !== 1'b0) begin bad++; $display("FAIL sat_flag_leak got=%0b exp=0", out_ovf18); end
  endtask

  task automatic test_clear();
    do_reset();
    in_valid = 1'b1; in_data = 16'd10; step();
    in_data = 16'd20; step();
    total++; if (cnt4 !== 2'd2) begin bad++; $display("FAIL clr_cnt_before got=%0d exp=2", cnt4); end
    clear = 1'b1; in_data = 16'd30; step();
    clear = 1'b0;
    total++; if (cnt4 !== 2'd0) begin bad++; $display("FAIL clr_cnt got=%0d exp=0", cnt4); end
    total++; if (st4 !== 2'd0) begin bad++; $display("FAIL clr_state got=%0d exp=0", st4); end
    for (int i = 1; i <= 4; i++) begin
      in_data = 16'(i); step();
    end
    in_valid = 1'b0;
    total++; if (out_valid4 !== 1'b1) begin bad++; $display("FAIL clr_valid got=%0b exp=1", out_valid4); end
    total++; if (out_data4 !== 24'd10) begin bad++; $display("FAIL clr_data got=%0d exp=10", out_data4); end
    clear = 1'b1; step();
    clear = 1'b0;
    total++; if (out_valid4 !== 1'b0) begin bad++; $display("FAIL clr_hold_valid got=%0b exp=0", out_valid4); end
    total++; if (out_data4 !== 24'd10) begin bad++; $display("FAIL clr_keep_data got=%0d exp=10", out_data4); end
    total++; if (in_ready4 !== 1'b1) begin bad++; $display("FAIL clr_hold_ready got=%0b exp=1", in_ready4); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] prod [3];
    prod[0] = 16'd5; prod[1] = 16'd6; prod[2] = 16'd7;
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = prod[0];
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (out_valid1 !== 1'b1) begin bad++; $display("FAIL b2b_valid k=%0d got=%0b exp=1", k, out_valid1); end
      total++; if (out_data1 !== 24'(prod[k])) begin bad++; $display("FAIL b2b_data k=%0d got=%0d exp=%0d", k, out_data1, prod[k]); end
      total++; if (in_ready1 !== 1'b0) begin bad++; $display("FAIL b2b_bubble k=%0d got=%0b exp=0", k, in_ready1); end
      if (k < 2) in_data = prod[k+1];
      else in_valid = 1'b0;
      step();
      total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL b2b_gap_valid k=%0d got=%0b exp=0", k, out_valid1); end
      total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL b2b_gap_ready k=%0d got=%0b exp=1", k, in_ready1); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; in_data = 16'd1;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (out_data8 !== 24'd8) begin bad++; $display("FAIL arst_first_data got=%0d exp=8", out_data8); end
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd4;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    total++; if (cnt8 !== 3'd3) begin bad++; $display("FAIL arst_cnt_before got=%0d exp=3", cnt8); end
    #2 rstn = 1'b0;
    #1;
    total++; if (out_valid8 !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0b exp=0", out_valid8); end
    total++; if (out_data8 !== 24'd0) begin bad++; $display("FAIL arst_data got=%0d exp=0", out_data8); end
    total++; if (cnt8 !== 3'd0) begin bad++; $display("FAIL arst_cnt got=%0d exp=0", cnt8); end
    total++; if (st8 !== 2'd0) begin bad++; $display("FAIL arst_state got=%0d exp=0", st8); end
    step();
    rstn = 1'b1;
    in_valid = 1'b1; in_data = 16'd2;
    for (int i = 0; i < 8; i++) step();
    in_valid = 1'b0;
    total++; if (out_valid8 !== 1'b1) begin bad++; $display("FAIL arst_next_valid got=%0b exp=1", out_valid8); end
    total++; if (out_data8 !== 24'd16) begin bad++; $display("FAIL arst_next_data got=%0d exp=16", out_data8); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_len8();
    test_hold();
    test_saturate();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_accum.md
Name: dot_accum

Overview:
- Downstream stage of the registered 8x8 unsigned multiplier.
- Consumes the 16-bit product stream and sums LEN consecutive products into one dot-product result.
- Presents the result on a registered valid/ready output port and stalls the stream while the result is unconsumed.
- The upstream sequencer aligns in_valid with the multiplier's 2-cycle latency; this block does no realignment.

Parameters:
IN_W, 16, product width (multiplier output width)
ACC_W, 24, accumulator/result width; legal range IN_W..32
LEN, 8, products per dot product; legal range 1..256

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
clear  input  1  synchronous abort: drop partial sum and pending result
in_valid  input  1  in_data carries a product this cycle
in_data  input  IN_W  unsigned product from multiplier output
in_ready  output  1  block accepts in_data this cycle
out_valid  output  1  out_data/out_ovf hold a completed result
out_data  output  ACC_W  dot-product sum, saturated
out_ovf  output  1  saturation occurred within this result's window
out_ready  input  1  consumer takes the result this cycle

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, acc=0, cnt=0, ovf_flag=0, out_valid=0, out_data=0, out_ovf=0. in_ready is 1 immediately after reset.
- States:
  - IDLE: no partial sum.
  - ACCUM: 1..LEN-1 products summed.
  - HOLD: result pending.
- in_ready = (state != HOLD), combinational from state only; no dependence on out_ready.
- Accept = in_valid & in_ready. in_data is zero-extended to ACC_W+1 bits and added to the base.
  - Base = 0 in IDLE, acc in ACCUM.
  - If the sum exceeds 2^ACC_W-1, clamp to 2^ACC_W-1 and set ovf_flag.
  - A saturated acc stays saturated for the rest of the window.
- Accept with cnt < LEN-1: acc <= clamped sum, cnt <= cnt+1, state=ACCUM.
- Accept with cnt == LEN-1:
  - out_data <= clamped sum; out_ovf <= ovf_flag | this-cycle overflow.
  - out_valid <= 1, state=HOLD.
  - cnt <= 0, acc <= 0, ovf_flag <= 0.
  - Latency: out_valid is high the cycle after the LEN-th accept.
- LEN=1: every accept goes straight to HOLD; IDLE->HOLD directly.
- in_valid=0 in IDLE/ACCUM: no state change. Gaps between products are allowed and do not reset the window.
- HOLD:
  - out_data/out_ovf stable while out_valid=1.
  - out_ready=1 -> out_valid <= 0, state=IDLE next cycle.
  - in_valid in HOLD is not accepted; the upstream must hold the product, which costs a minimum 1-cycle bubble per result.
- out_ready while out_valid=0: ignored.
- clear=1 (highest synchronous priority, overrides accept and out_ready):
  - acc=0, cnt=0, ovf_flag=0, out_valid=0, out_ovf=0, state=IDLE.
  - out_data retains its last value.
  - The in_data offered that cycle is not counted, even if in_ready was 1.
- Reset asserted mid-window or in HOLD: immediate return to reset values; no partial result is emitted.
- cnt width = clog2(LEN) bits, minimum 1. cnt never exceeds LEN-1.

Test Plan:
- Reset then LEN=8, products 1..8 back-to-back with out_ready=1 -> out_valid one cycle after 8th accept, out_data=36, out_ovf=0; in_ready low exactly one cycle.
- LEN=4, products 65025 x4, out_ready held 0 for 5 cycles -> out_data=260100 stable, in_ready=0 throughout HOLD, the next product (7) is held by the upstream and accepted the cycle after out_ready rises; the next window starts from 7.
- ACC_W=18, LEN=8, 65025 x8 -> out_data=262143, out_ovf=1; following window 1 x8 -> out_data=8, out_ovf=0 (flag does not leak).
- LEN=4, products 10,20 then clear=1 together with in_valid (30) -> 30 discarded; then 1,2,3,4 -> out_data=10.
- LEN=1, stream 5,6,7 with in_valid held high, out_ready=1 -> results 5,6,7 each separated by one in_ready=0 bubble.
- rstn pulsed low asynchronously mid-cycle during ACCUM (cnt=3) -> out_valid/out_data/cnt immediately 0; the next 8 products 2 each -> out_data=16.
